// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the mips32 instruction fetch stage
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000D;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mips_instr_fetch_if.sv
// rtl/mips_instr_fetch_if.sv - host/datapath bundle of the fetch stage
// Breakpoint signals exist only with MIPS_FETCH_BREAKPOINT_EN defined.
interface mips_instr_fetch_if #(
  parameter int IMEM_DEPTH = 64
);
  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              start;
  logic              stall;
  logic [31:0]       instruction;
  logic              instr_valid;
  logic [31:0]       pc;
  logic [31:0]       retired_count;
  logic              busy;
  logic              halted;
`ifdef MIPS_FETCH_BREAKPOINT_EN
  logic              bp_en;
  logic [31:0]       bp_addr;
  logic              resume;
  logic              bp_hit;
`endif

  modport master (
`ifdef MIPS_FETCH_BREAKPOINT_EN
    output bp_en, bp_addr, resume,
    input  bp_hit,
`endif
    output load_en, load_addr, load_data, start, stall,
    input  instruction, instr_valid, pc, retired_count, busy, halted
  );

  modport slave (
`ifdef MIPS_FETCH_BREAKPOINT_EN
    input  bp_en, bp_addr, resume,
    output bp_hit,
`endif
    input  load_en, load_addr, load_data, start, stall,
    output instruction, instr_valid, pc, retired_count, busy, halted
  );

endinterface

// File: rtl/mips_instr_rom.sv
// rtl/mips_instr_rom.sv - loadable instruction memory, synchronous write, asynchronous read
module mips_instr_rom #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_instr_fetch.sv
// rtl/mips_instr_fetch.sv - fetch stage feeding one registered instruction (or NOP) per clock
// Optional breakpoint/resume logic under MIPS_FETCH_BREAKPOINT_EN.
module mips_instr_fetch
  import mips_fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] HALT_WORD  = mips_fetch_pkg::DEFAULT_HALT_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_instr_fetch_if.slave bus
);

  localparam int          ADDR_W  = $clog2(IMEM_DEPTH);
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic [31:0]  retired_q, retired_d;
  logic [31:0]  rom_word;
  logic         rom_we;

`ifdef MIPS_FETCH_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  logic bp_stop_q, bp_stop_d;
  logic bp_skip_q, bp_skip_d;
`endif

  assign rom_we = bus.load_en && (state_q != ST_RUN);

  mips_instr_rom #(
    .DEPTH  (IMEM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk     (clk),
    .we_i    (rom_we),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data),
    .raddr_i (pc_q[2 +: ADDR_W]),
    .rdata_o (rom_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      instr_q   <= NOP_WORD;
      valid_q   <= 1'b0;
      retired_q <= '0;
`ifdef MIPS_FETCH_BREAKPOINT_EN
      bp_hit_q  <= 1'b0;
      bp_stop_q <= 1'b0;
      bp_skip_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      retired_q <= retired_d;
`ifdef MIPS_FETCH_BREAKPOINT_EN
      bp_hit_q  <= bp_hit_d;
      bp_stop_q <= bp_stop_d;
      bp_skip_q <= bp_skip_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = NOP_WORD;
    valid_d   = 1'b0;
    retired_d = retired_q;
`ifdef MIPS_FETCH_BREAKPOINT_EN
    bp_hit_d  = bp_hit_q;
    bp_stop_d = bp_stop_q;
    bp_skip_d = bp_skip_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          pc_d      = '0;
          retired_d = '0;
`ifdef MIPS_FETCH_BREAKPOINT_EN
          bp_hit_d  = 1'b0;
          bp_stop_d = 1'b0;
          bp_skip_d = 1'b0;
        end else if (bus.resume && bp_stop_q && state_q == ST_HALT) begin
          // Resume from a breakpoint: the pc still equals bp_addr, so skip one compare.
          state_d   = ST_RUN;
          bp_stop_d = 1'b0;
          bp_skip_d = 1'b1;
`endif
        end
      end

      ST_RUN: begin
        if (!bus.stall) begin
`ifdef MIPS_FETCH_BREAKPOINT_EN
          bp_skip_d = 1'b0;
          if (bus.bp_en && pc_q == bus.bp_addr && !bp_skip_q) begin
            state_d   = ST_HALT;
            bp_hit_d  = 1'b1;
            bp_stop_d = 1'b1;
          end else
`endif
          if (pc_q >= PC_LIMIT || rom_word == HALT_WORD) begin
            state_d = ST_HALT;
          end else begin
            instr_d   = rom_word;
            valid_d   = 1'b1;
            pc_d      = pc_q + PC_STEP;
            retired_d = sat_inc(retired_q);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.instruction   = instr_q;
  assign bus.instr_valid   = valid_q;
  assign bus.pc            = pc_q;
  assign bus.retired_count = retired_q;
  assign bus.busy          = (state_q == ST_RUN);
  assign bus.halted        = (state_q == ST_HALT);
`ifdef MIPS_FETCH_BREAKPOINT_EN
  assign bus.bp_hit        = bp_hit_q;
`endif

endmodule

// File: tb/tb_mips_instr_fetch.sv
// tb/tb_mips_instr_fetch.sv - directed table-driven bench for mips_instr_fetch
module tb_mips_instr_fetch;

  localparam logic [31:0] ADD = 32'h0022_1820;
  localparam logic [31:0] SUB = 32'h0022_1822;
  localparam logic [31:0] BRK = 32'h0000_000D;
  localparam logic [31:0] A0  = 32'h0000_0020;
  localparam logic [31:0] FF  = 32'hFFFF_FFFF;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mips_instr_fetch_if #(.IMEM_DEPTH(64)) bus ();

  mips_instr_fetch #(.IMEM_DEPTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        start;
    logic        stall;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ret;
    logic        e_busy;
    logic        e_halt;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [5:0] addr, input logic [31:0] data,
                       input logic st, input logic sl);
    @(negedge clk);
    bus.load_en   = ld;
    bus.load_addr = addr;
    bus.load_data = data;
    bus.start     = st;
    bus.stall     = sl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ins, input logic v,
                         input logic [31:0] p, input logic [31:0] r, input logic b, input logic h);
    chk({tag, ".instruction"}, bus.instruction, ins);
    chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(v));
    chk({tag, ".pc"}, bus.pc, p);
    chk({tag, ".retired"}, bus.retired_count, r);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(h));
  endtask

  initial begin
    int issued;
    errors = 0;
    checks = 0;

    vecs[0]  = '{1'b1, 6'd0, ADD, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 6'd1, SUB, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 6'd2, BRK, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, ADD, 1'b1, 32'd4, 32'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, SUB, 1'b1, 32'd8, 32'd2, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd8, 32'd2, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd8, 32'd2, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, ADD, 1'b1, 32'd4, 32'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'd4, 32'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'd4, 32'd1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'd4, 32'd1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, SUB, 1'b1, 32'd8, 32'd2, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd8, 32'd2, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 6'd1, FF, 1'b0, 1'b0, ADD, 1'b1, 32'd4, 32'd1, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, SUB, 1'b1, 32'd8, 32'd2, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd8, 32'd2, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 6'd0, A0, 1'b1, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, A0, 1'b1, 32'd4, 32'd1, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, SUB, 1'b1, 32'd8, 32'd2, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd8, 32'd2, 1'b0, 1'b1};
    vecs[23] = '{1'b1, 6'd0, ADD, 1'b0, 1'b0, 32'h0, 1'b0, 32'd8, 32'd2, 1'b0, 1'b1};

    rst_n         = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
`ifdef MIPS_FETCH_BREAKPOINT_EN
    bus.bp_en     = 1'b0;
    bus.bp_addr   = '0;
    bus.resume    = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].ld, vecs[i].addr, vecs[i].data, vecs[i].start, vecs[i].stall);
      chk_out($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_pc,
              vecs[i].e_ret, vecs[i].e_busy, vecs[i].e_halt);
    end

    // Reset during the second issue cycle, then rerun the kept program.
    drive(1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
    chk_out("pre_rst", SUB, 1'b1, 32'd8, 32'd2, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
    chk_out("rerun_start", 32'h0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
    chk_out("rerun_add", ADD, 1'b1, 32'd4, 32'd1, 1'b1, 1'b0);
    drive(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
    chk_out("rerun_sub", SUB, 1'b1, 32'd8, 32'd2, 1'b1, 1'b0);
    drive(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
    chk_out("rerun_halt", 32'h0, 1'b0, 32'd8, 32'd2, 1'b0, 1'b1);

`ifdef MIPS_FETCH_BREAKPOINT_EN
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'd4;
    drive(1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
    chk("bp_start.bp_hit", 32'(bus.bp_hit), 32'd0);
    drive(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
    chk_out("bp_add", ADD, 1'b1, 32'd4, 32'd1, 1'b1, 1'b0);
    drive(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
    chk_out("bp_stop", 32'h0, 1'b0, 32'd4, 32'd1, 1'b0, 1'b1);
    chk("bp_stop.bp_hit", 32'(bus.bp_hit), 32'd1);
    @(negedge clk);
    bus.resume = 1'b1;
    @(posedge clk);
    #1;
    chk_out("bp_resume", 32'h0, 1'b0, 32'd4, 32'd1, 1'b1, 1'b0);
    @(negedge clk);
    bus.resume = 1'b0;
    @(posedge clk);
    #1;
    chk_out("bp_sub", SUB, 1'b1, 32'd8, 32'd2, 1'b1, 1'b0);
    drive(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
    chk_out("bp_end", 32'h0, 1'b0, 32'd8, 32'd2, 1'b0, 1'b1);
    chk("bp_end.bp_hit", 32'(bus.bp_hit), 32'd1);
    bus.bp_en = 1'b0;
`endif

    // Full memory without a halt word runs off the end.
    for (int a = 0; a < 64; a++) begin
      drive(1'b1, 6'(a), A0, 1'b0, 1'b0);
    end
    drive(1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
    issued = 0;
    for (int c = 0; c < 80; c++) begin
      drive(1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
      if (bus.instr_valid) issued++;
      if (bus.halted) break;
    end
    chk("fill.issued", 32'(issued), 32'd64);
    chk_out("fill_end", 32'h0, 1'b0, 32'd256, 32'd64, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
